// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEMACC/WBACK FSM with a
// sticky illegal-opcode trap and a wrapping retired-instruction counter.
module multicycle_ctrl #(
  parameter int OPW    = 4,
  parameter int ALUOPW = 2,
  parameter int CNTW   = 16
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic [OPW-1:0]    OPCODE,
  input  logic              MemReady,
  input  logic              Zero,
  output logic              PCWrite,
  output logic              IRWrite,
  output logic              IorD,
  output logic              RegDst,
  output logic              Branch,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MemToReg,
  output logic              AluSrc,
  output logic              RegWrite,
  output logic [ALUOPW-1:0] AluOp,
  output logic              IllegalOp,
  output logic [2:0]        State,
  output logic [CNTW-1:0]   Retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEMACC = 3'd3,
    WBACK  = 3'd4,
    TRAP   = 3'd5
  } stateT;

  localparam logic [OPW-1:0] OP_R    = OPW'(4'b0110);
  localparam logic [OPW-1:0] OP_LS   = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_SS   = OPW'(4'b0011);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(4'b0100);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(4'b0001);

  stateT          state;
  stateT          nextState;
  logic [OPW-1:0] opReg;
  logic [1:0]     aluOpCls;
  logic           retire;
  logic           opLegal;

  // Full-width compare: any set bit above the 4-bit code makes the opcode illegal.
  assign opLegal = (OPCODE == OP_R) || (OPCODE == OP_LS) || (OPCODE == OP_SS) ||
                   (OPCODE == OP_BEQ) || (OPCODE == OP_ADDI);

  assign State = state;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    nextState = state;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    IorD      = 1'b0;
    RegDst    = 1'b0;
    Branch    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemToReg  = 1'b0;
    AluSrc    = 1'b0;
    RegWrite  = 1'b0;
    aluOpCls  = 2'b00;
    retire    = 1'b0;

    case (state)
      FETCH: begin
        MemRead = 1'b1;
        AluSrc  = 1'b1;
        if (MemReady) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          nextState = DECODE;
        end
      end

      DECODE: nextState = opLegal ? EXEC : TRAP;

      EXEC: begin
        case (opReg)
          OP_R: begin
            aluOpCls  = 2'b10;
            nextState = WBACK;
          end
          OP_ADDI: begin
            AluSrc    = 1'b1;
            nextState = WBACK;
          end
          OP_LS, OP_SS: begin
            AluSrc    = 1'b1;
            nextState = MEMACC;
          end
          OP_BEQ: begin
            aluOpCls  = 2'b01;
            Branch    = 1'b1;
            PCWrite   = Zero;
            retire    = 1'b1;
            nextState = FETCH;
          end
          default: nextState = TRAP;
        endcase
      end

      MEMACC: begin
        IorD     = 1'b1;
        AluSrc   = 1'b1;
        MemRead  = (opReg == OP_LS);
        MemWrite = (opReg == OP_SS);
        if (MemReady) begin
          retire    = (opReg == OP_SS);
          nextState = (opReg == OP_LS) ? WBACK : FETCH;
        end
      end

      WBACK: begin
        RegWrite  = 1'b1;
        RegDst    = (opReg == OP_R);
        MemToReg  = (opReg == OP_LS);
        retire    = 1'b1;
        nextState = FETCH;
      end

      TRAP: nextState = TRAP;

      default: nextState = FETCH;
    endcase

    AluOp      = '0;
    AluOp[1:0] = aluOpCls;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state     <= FETCH;
      opReg     <= '0;
      IllegalOp <= 1'b0;
      Retired   <= '0;
    end else begin
      state <= nextState;
      if (state == DECODE) begin
        opReg <= OPCODE;
        if (!opLegal) IllegalOp <= 1'b1;
      end
      if (retire) Retired <= Retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: expected control vectors are queued on a
// scoreboard as each cycle is driven and popped when the outputs are sampled.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic       irw;
    logic       iord;
    logic       regdst;
    logic       branch;
    logic       memrd;
    logic       memwr;
    logic       mem2reg;
    logic       alusrc;
    logic       regwr;
    logic [1:0] aluop;
    logic       ill;
  } ctl_t;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  localparam ctl_t C_FETCH     = '{st: 3'd0, memrd: 1'b1, alusrc: 1'b1, default: '0};
  localparam ctl_t C_FETCH_RDY = '{st: 3'd0, memrd: 1'b1, alusrc: 1'b1, pcw: 1'b1, irw: 1'b1, default: '0};
  localparam ctl_t C_DEC       = '{st: 3'd1, default: '0};
  localparam ctl_t C_EX_R      = '{st: 3'd2, aluop: 2'b10, default: '0};
  localparam ctl_t C_EX_I      = '{st: 3'd2, alusrc: 1'b1, default: '0};
  localparam ctl_t C_EX_BT     = '{st: 3'd2, aluop: 2'b01, branch: 1'b1, pcw: 1'b1, default: '0};
  localparam ctl_t C_EX_BN     = '{st: 3'd2, aluop: 2'b01, branch: 1'b1, default: '0};
  localparam ctl_t C_MEM_LS    = '{st: 3'd3, iord: 1'b1, alusrc: 1'b1, memrd: 1'b1, default: '0};
  localparam ctl_t C_MEM_SS    = '{st: 3'd3, iord: 1'b1, alusrc: 1'b1, memwr: 1'b1, default: '0};
  localparam ctl_t C_WB_R      = '{st: 3'd4, regwr: 1'b1, regdst: 1'b1, default: '0};
  localparam ctl_t C_WB_LS     = '{st: 3'd4, regwr: 1'b1, mem2reg: 1'b1, default: '0};
  localparam ctl_t C_WB_I      = '{st: 3'd4, regwr: 1'b1, default: '0};
  localparam ctl_t C_TRAP      = '{st: 3'd5, ill: 1'b1, default: '0};

  logic        Clock;
  logic        ResetN;
  logic        ResetN2;
  logic [3:0]  OPCODE;
  logic        MemReady;
  logic        Zero;

  logic        PCWrite, IRWrite, IorD, RegDst, Branch, MemRead, MemWrite;
  logic        MemToReg, AluSrc, RegWrite, IllegalOp;
  logic [1:0]  AluOp;
  logic [2:0]  State;
  logic [15:0] Retired;

  logic        d2PCWrite, d2IRWrite, d2IorD, d2RegDst, d2Branch, d2MemRead, d2MemWrite;
  logic        d2MemToReg, d2AluSrc, d2RegWrite, d2IllegalOp;
  logic [1:0]  d2AluOp;
  logic [2:0]  d2State;
  logic [1:0]  d2Retired;

  ctl_t        obsCtl;
  exp_t        sb[$];
  int          nCmp  = 0;
  int          nFail = 0;

  multicycle_ctrl dut (
    .Clock(Clock), .ResetN(ResetN), .OPCODE(OPCODE), .MemReady(MemReady), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .RegDst(RegDst), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .AluSrc(AluSrc),
    .RegWrite(RegWrite), .AluOp(AluOp), .IllegalOp(IllegalOp), .State(State),
    .Retired(Retired)
  );

  multicycle_ctrl #(.CNTW(2)) dut2 (
    .Clock(Clock), .ResetN(ResetN2), .OPCODE(OPCODE), .MemReady(MemReady), .Zero(Zero),
    .PCWrite(d2PCWrite), .IRWrite(d2IRWrite), .IorD(d2IorD), .RegDst(d2RegDst),
    .Branch(d2Branch), .MemRead(d2MemRead), .MemWrite(d2MemWrite), .MemToReg(d2MemToReg),
    .AluSrc(d2AluSrc), .RegWrite(d2RegWrite), .AluOp(d2AluOp), .IllegalOp(d2IllegalOp),
    .State(d2State), .Retired(d2Retired)
  );

  assign obsCtl = {State, PCWrite, IRWrite, IorD, RegDst, Branch, MemRead, MemWrite,
                   MemToReg, AluSrc, RegWrite, AluOp, IllegalOp};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs);
    exp_t e;
    nCmp++;
    if (sb.size() == 0) begin
      nFail++;
      $error("FAIL %s: observed %0h with no expected entry queued", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        nFail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e.val);
      end
    end
  endtask

  task automatic chkNow(input string tag, input logic [31:0] expVal, input logic [31:0] obs);
    sb.push_back('{tag: tag, val: expVal});
    check(tag, obs);
  endtask

  // One clock: queue the expectation, sample at the falling edge, advance past the rising edge.
  task automatic cyc(input string tag, input ctl_t e);
    sb.push_back('{tag: tag, val: 32'(e)});
    @(negedge Clock);
    check(tag, 32'(obsCtl));
    @(posedge Clock);
    #1;
  endtask

  task automatic runAddi(input string tag);
    OPCODE   = 4'b0001;
    MemReady = 1'b1;
    cyc({tag, "_fetch"}, C_FETCH_RDY);
    cyc({tag, "_dec"},   C_DEC);
    cyc({tag, "_exec"},  C_EX_I);
    cyc({tag, "_wb"},    C_WB_I);
  endtask

  task automatic pulseReset(input string tag);
    MemReady = 1'b0;
    ResetN   = 1'b0;
    #1;
    chkNow({tag, "_ctl"}, 32'(C_FETCH), 32'(obsCtl));
    chkNow({tag, "_ret"}, 32'd0, 32'(Retired));
    @(posedge Clock);
    #1;
    ResetN = 1'b1;
  endtask

  initial begin
    logic [1:0] wrapSeq [5];
    wrapSeq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    ResetN   = 1'b0;
    ResetN2  = 1'b0;
    OPCODE   = 4'b0000;
    MemReady = 1'b0;
    Zero     = 1'b0;
    #12;
    chkNow("rst_ctl", 32'(C_FETCH), 32'(obsCtl));
    chkNow("rst_ret", 32'd0, 32'(Retired));
    @(posedge Clock);
    #1;
    ResetN = 1'b1;

    // R-type with MemReady held high
    OPCODE   = 4'b0110;
    MemReady = 1'b1;
    cyc("r_fetch", C_FETCH_RDY);
    cyc("r_dec",   C_DEC);
    cyc("r_exec",  C_EX_R);
    cyc("r_wb",    C_WB_R);
    chkNow("r_ret", 32'd1, 32'(Retired));

    // Load with three wait cycles in MEMACC
    OPCODE = 4'b0010;
    cyc("ls_fetch", C_FETCH_RDY);
    cyc("ls_dec",   C_DEC);
    cyc("ls_exec",  C_EX_I);
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ls_memwait", C_MEM_LS);
    MemReady = 1'b1;
    cyc("ls_memdone", C_MEM_LS);
    cyc("ls_wb",      C_WB_LS);
    chkNow("ls_ret", 32'd2, 32'(Retired));

    // BEQ taken, then not taken
    OPCODE = 4'b0100;
    Zero   = 1'b1;
    cyc("beq1_fetch", C_FETCH_RDY);
    cyc("beq1_dec",   C_DEC);
    cyc("beq1_exec",  C_EX_BT);
    chkNow("beq1_ret", 32'd3, 32'(Retired));
    Zero = 1'b0;
    cyc("beq0_fetch", C_FETCH_RDY);
    cyc("beq0_dec",   C_DEC);
    cyc("beq0_exec",  C_EX_BN);
    chkNow("beq0_ret", 32'd4, 32'(Retired));

    // FETCH stalls without MemReady
    MemReady = 1'b0;
    cyc("fetch_stall", C_FETCH);
    runAddi("addi");
    chkNow("addi_ret", 32'd5, 32'(Retired));

    // Store with one wait cycle; retires out of MEMACC
    OPCODE = 4'b0011;
    cyc("ss_fetch", C_FETCH_RDY);
    cyc("ss_dec",   C_DEC);
    cyc("ss_exec",  C_EX_I);
    MemReady = 1'b0;
    cyc("ss_memwait", C_MEM_SS);
    MemReady = 1'b1;
    cyc("ss_memdone", C_MEM_SS);
    chkNow("ss_ret", 32'd6, 32'(Retired));

    // Illegal opcode: trap is sticky and ignores MemReady
    OPCODE = 4'b1111;
    cyc("ill_fetch", C_FETCH_RDY);
    cyc("ill_dec",   C_DEC);
    for (int i = 0; i < 20; i++) begin
      MemReady = i[0];
      cyc("trap_hold", C_TRAP);
    end
    chkNow("trap_ret", 32'd6, 32'(Retired));
    pulseReset("trap_clr");

    // Reset during a store's MEMACC wait abandons it
    runAddi("pre_ss");
    chkNow("pre_ss_ret", 32'd1, 32'(Retired));
    OPCODE   = 4'b0011;
    MemReady = 1'b1;
    cyc("ssab_fetch", C_FETCH_RDY);
    cyc("ssab_dec",   C_DEC);
    cyc("ssab_exec",  C_EX_I);
    MemReady = 1'b0;
    cyc("ssab_memwait", C_MEM_SS);
    pulseReset("ssab_rst");

    // Differs from the R opcode only in the top bit
    OPCODE   = 4'b1110;
    MemReady = 1'b1;
    cyc("ill2_fetch", C_FETCH_RDY);
    cyc("ill2_dec",   C_DEC);
    cyc("ill2_trap",  C_TRAP);
    pulseReset("ill2_clr");

    // Narrow counter wraps: both instances run the same five ADDIs
    ResetN2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      runAddi("wrap");
      chkNow("wrap_ret16", 32'(i + 1), 32'(Retired));
      chkNow("wrap_ret2", 32'(wrapSeq[i]), 32'(d2Retired));
    end
    chkNow("wrap_state2", 32'd0, 32'(d2State));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
